// File: rtl/cpu_pkg.sv
// Shared types for the teaching-CPU step controller: phase encoding and PC width.
package cpu_pkg;

    localparam int PC_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Panel button front end: 2-FF synchronizer, level debounce, one-cycle rising-edge pulse.
// press_o fires 2 + DEBOUNCE_CYCLES cycles after a clean btn_raw_i rise; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only advances while the synchronized sample disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Phase sequencer: button press -> one-hot FETCH/DECODE/EXEC/WB strobes, single-step or free-run.
// One phase per cycle, 4-cycle instruction period; presses while busy only request a free-run stop.
module cpu_step_ctrl
    import cpu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic             mode_run,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic             halt_op,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             wb_en,
    output logic             busy,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    logic             running_q, running_d;
    logic             stop_req_q, stop_req_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             press;
    logic             bp_hit;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk       (clk),
        .rst       (rst),
        .btn_raw_i (btn_raw),
        .press_o   (press)
    );

    // pc during WB is the next instruction's address, so a hit stops before bp_addr executes.
    assign bp_hit = bp_en && (pc == bp_addr);

    always_comb begin
        state_d    = state_q;
        running_d  = running_q;
        stop_req_d = stop_req_q;
        retired_d  = retired_q;

        if (press && busy && running_q) begin
            stop_req_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d    = ST_FETCH;
                    running_d  = mode_run;
                    stop_req_d = 1'b0;
                end
            end
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (halt_op) begin
                    state_d    = ST_HALT;
                    running_d  = 1'b0;
                    stop_req_d = 1'b0;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                retired_d = retired_q + 1'b1;
                if (!running_q) begin
                    state_d = ST_IDLE;
                end else if (stop_req_q || bp_hit) begin
                    state_d    = ST_IDLE;
                    running_d  = 1'b0;
                    stop_req_d = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            running_q  <= 1'b0;
            stop_req_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            running_q  <= running_d;
            stop_req_q <= stop_req_d;
            retired_q  <= retired_d;
        end
    end

    assign fetch_en  = (state_q == ST_FETCH);
    assign decode_en = (state_q == ST_DECODE);
    assign exec_en   = (state_q == ST_EXEC);
    assign wb_en     = (state_q == ST_WB);
    assign busy      = fetch_en | decode_en | exec_en | wb_en;
    assign running   = running_q;
    assign halted    = (state_q == ST_HALT);
    assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl; a narrow-counter twin shares the stimulus to exercise wrap.
module tb_cpu_step_ctrl;

    logic        clk;
    logic        rst;
    logic        btn_raw;
    logic        mode_run;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [7:0]  pc;
    logic        halt_op;
    logic        fetch_en, decode_en, exec_en, wb_en, busy, running, halted;
    logic [15:0] retired;
    logic        w_fetch_en, w_decode_en, w_exec_en, w_wb_en, w_busy, w_running, w_halted;
    logic [2:0]  retired_w;

    int checks = 0;
    int errors = 0;
    int wbs;
    logic seen;
    logic saw_run;

    cpu_step_ctrl dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .mode_run(mode_run),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .halt_op(halt_op),
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en),
        .busy(busy), .running(running), .halted(halted), .retired(retired)
    );

    cpu_step_ctrl #(.CNT_W(3)) dut_w (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .mode_run(mode_run),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .halt_op(halt_op),
        .fetch_en(w_fetch_en), .decode_en(w_decode_en), .exec_en(w_exec_en), .wb_en(w_wb_en),
        .busy(w_busy), .running(w_running), .halted(w_halted), .retired(retired_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // {fetch, decode, exec, wb, busy, running, halted}
    function automatic logic [6:0] outs();
        return {fetch_en, decode_en, exec_en, wb_en, busy, running, halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; btn_raw = 1'b0; mode_run = 1'b0; bp_en = 1'b0;
        bp_addr = 8'h00; pc = 8'h00; halt_op = 1'b0;

        step(2);
        chk("reset_outs", 32'(outs()), 32'h00);
        chk("reset_retired", 32'(retired), 32'd0);
        rst = 1'b0;
        step(1);

        // Single step: press lands 6 cycles after the rise, then 4 one-hot strobes.
        btn_raw = 1'b1;
        step(5);
        chk("t1_press_early", 32'(dut.press), 32'd0);
        step(1);
        chk("t1_press", 32'(dut.press), 32'd1);
        chk("t1_idle_at_press", 32'(outs()), 32'h00);
        step(1);
        chk("t1_fetch", 32'(outs()), 32'b1000100);
        chk("t1_press_pulse", 32'(dut.press), 32'd0);
        step(1);
        chk("t1_decode", 32'(outs()), 32'b0100100);
        step(1);
        chk("t1_exec", 32'(outs()), 32'b0010100);
        step(1);
        chk("t1_wb", 32'(outs()), 32'b0001100);
        chk("t1_retired_in_wb", 32'(retired), 32'd0);
        step(1);
        chk("t1_idle", 32'(outs()), 32'h00);
        chk("t1_retired", 32'(retired), 32'd1);
        btn_raw = 1'b0;
        step(12);
        chk("t1_release_quiet", 32'(outs()), 32'h00);

        // Two-cycle glitch must not get through the debounce.
        btn_raw = 1'b1;
        step(2);
        btn_raw = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (dut.press || fetch_en) seen = 1'b1;
        end
        chk("t2_glitch", 32'(seen), 32'd0);
        chk("t2_retired", 32'(retired), 32'd1);

        // Free-run to breakpoint 0x03 with the bench advancing pc at each WB.
        mode_run = 1'b1; bp_en = 1'b1; bp_addr = 8'h03; pc = 8'h00;
        wbs = 0; saw_run = 1'b0;
        btn_raw = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (i == 8) btn_raw = 1'b0;
            if (running) saw_run = 1'b1;
            if (wb_en) begin
                pc = pc + 8'd1;
                wbs++;
            end
        end
        chk("t3_saw_running", 32'(saw_run), 32'd1);
        chk("t3_wb_count", 32'(wbs), 32'd3);
        chk("t3_retired", 32'(retired), 32'd4);
        chk("t3_pc", 32'(pc), 32'h03);
        chk("t3_stopped", 32'(outs()), 32'h00);

        // Free-run, second press lands in EXEC: only that instruction finishes.
        bp_en = 1'b0;
        btn_raw = 1'b1;
        step(8);
        btn_raw = 1'b0;
        step(15);
        chk("t4_fetch_run", 32'(outs()), 32'b1000110);
        chk("t4_retired_mid", 32'(retired), 32'd8);
        btn_raw = 1'b1;
        step(6);
        chk("t4_press_in_exec", 32'(dut.press), 32'd1);
        chk("t4_exec", 32'(outs()), 32'b0010110);
        step(1);
        chk("t4_wb", 32'(outs()), 32'b0001110);
        step(1);
        chk("t4_stopped", 32'(outs()), 32'h00);
        chk("t4_retired", 32'(retired), 32'd10);
        btn_raw = 1'b0;
        step(12);
        chk("t4_stays_idle", 32'(outs()), 32'h00);

        // Counter wrap on the 3-bit twin while the main counter keeps counting.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("w_reset_retired", 32'(retired), 32'd0);
        chk("w_reset_retired_w", 32'(retired_w), 32'd0);
        btn_raw = 1'b1;
        step(8);
        btn_raw = 1'b0;
        step(27);
        chk("w_retired_7", 32'(retired), 32'd7);
        chk("w_retired_w_7", 32'(retired_w), 32'd7);
        step(2);
        btn_raw = 1'b1;
        step(2);
        chk("w_retired_8", 32'(retired), 32'd8);
        chk("w_retired_w_wrap", 32'(retired_w), 32'd0);
        step(8);
        chk("w_stopped", 32'(outs()), 32'h00);
        chk("w_retired_10", 32'(retired), 32'd10);
        chk("w_retired_w_2", 32'(retired_w), 32'd2);
        btn_raw = 1'b0;
        step(12);

        // HALT during EXEC of the second instruction.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        btn_raw = 1'b1;
        step(8);
        btn_raw = 1'b0;
        step(5);
        chk("t5_exec2", 32'(outs()), 32'b0010110);
        chk("t5_retired_before", 32'(retired), 32'd1);
        halt_op = 1'b1;
        step(1);
        halt_op = 1'b0;
        chk("t5_halted", 32'(outs()), 32'b0000001);
        chk("t5_retired", 32'(retired), 32'd1);
        btn_raw = 1'b1;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (i == 10) btn_raw = 1'b0;
            if (fetch_en || wb_en) seen = 1'b1;
        end
        chk("t5_press_ignored", 32'(seen), 32'd0);
        chk("t5_still_halted", 32'(outs()), 32'b0000001);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t5_rst_clears", 32'(outs()), 32'h00);
        chk("t5_rst_retired", 32'(retired), 32'd0);

        // Reset asserted during DECODE wipes the instruction with no WB.
        mode_run = 1'b0;
        btn_raw = 1'b1;
        step(8);
        btn_raw = 1'b0;
        chk("t6_decode", 32'(outs()), 32'b0100100);
        rst = 1'b1;
        step(1);
        chk("t6_rst_outs", 32'(outs()), 32'h00);
        chk("t6_rst_retired", 32'(retired), 32'd0);
        rst = 1'b0;
        step(12);
        chk("t6_quiet", 32'(outs()), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
